alu_rr_arbiter: RTL and testbench

//  Shares one 8-bit, 3-bit-opcode ALU between NREQ requesters. Each requester presents
//  an operation over a valid/ready handshake. A round-robin arbiter grants one per cycle.
//  The ALU result is registered into a single output slot, tagged with the requester

---
 rtl/alu_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_alu_rr_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU between NREQ requesters.
// Single registered result slot, tagged with the winning requester id.
module alu_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [3*NREQ-1:0] req_opc,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [7:0]        res_data,
  output logic [IDW-1:0]    res_id,
  output logic              res_zero
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t         state_q, state_d;
  logic [7:0]     data_q, data_d;
  logic [IDW-1:0] id_q, id_d;
  logic           zero_q, zero_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gid;
  logic            found;
  logic            slot_free;
  logic            accept;
  logic [2:0]      opc;
  logic [7:0]      a, b;
  logic [7:0]      alu;

  assign slot_free = (state_q == EMPTY) | res_ready;

  // Rotating priority search: ptr..NREQ-1 first, then 0..ptr-1.
  always_comb begin
    gnt   = '0;
    gid   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && i >= int'(ptr_q) && req_valid[i]) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        gid    = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && i < int'(ptr_q) && req_valid[i]) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        gid    = IDW'(i);
      end
    end
  end

  assign req_ready = (slot_free && rst_n) ? gnt : '0;
  assign accept    = |req_ready;

  // Operand mux driven by the one-hot grant.
  always_comb begin
    opc = '0;
    a   = '0;
    b   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        opc = req_opc[3*i +: 3];
        a   = req_a[8*i +: 8];
        b   = req_b[8*i +: 8];
      end
    end
  end

  // ALU: low two opcode bits pick the op, bit 2 inverts.
  always_comb begin
    alu = '0;
    unique case (opc[1:0])
      2'd0: alu = a + b;
      2'd1: alu = a - b;
      2'd2: alu = a & b;
      2'd3: alu = a | b;
      default: alu = '0;
    endcase
    if (opc[2]) alu = ~alu;
  end

  // Slot FSM and result/pointer next-state.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    zero_d  = zero_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL: begin
        if (accept)         state_d = FULL;
        else if (res_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      data_d = alu;
      id_d   = gid;
      zero_d = (alu == 8'h00);
      if (int'(gid) == NREQ - 1) ptr_d = '0;
      else                       ptr_d = gid + 1'b1;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      id_q    <= '0;
      zero_q  <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      zero_q  <= zero_d;
      ptr_q   <= ptr_d;
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_data  = data_q;
  assign res_id    = id_q;
  assign res_zero  = zero_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: vector table plus
// hand-written round-robin, backpressure and reset sequences.
module tb_alu_rr_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [3*NREQ-1:0] req_opc;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic              res_ready;
  logic [7:0]        res_data;
  logic [IDW-1:0]    res_id;
  logic              res_zero;

  int pass_cnt = 0;
  int total    = 0;

  alu_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_opc(req_opc),
    .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id),
    .res_zero(res_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [2:0] opc;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_data;
    logic       exp_zero;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setreq(input int i, input logic [2:0] o,
                        input logic [7:0] va, input logic [7:0] vb);
    req_opc[3*i +: 3] = o;
    req_a[8*i +: 8]   = va;
    req_b[8*i +: 8]   = vb;
  endtask

  function automatic logic [7:0] alu_m(input logic [2:0] o,
                                       input logic [7:0] x,
                                       input logic [7:0] y);
    case (o)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return ~(x + y);
      3'd5: return ~(x - y);
      3'd6: return ~(x & y);
      default: return ~(x | y);
    endcase
  endfunction

  initial begin
    vecs[0]  = '{0, 3'd0, 8'hF0, 8'h20, 8'h10, 1'b0};
    vecs[1]  = '{0, 3'd0, 8'h0F, 8'h01, 8'h10, 1'b0};
    vecs[2]  = '{0, 3'd1, 8'h0F, 8'h01, 8'h0E, 1'b0};
    vecs[3]  = '{0, 3'd2, 8'h0F, 8'h01, 8'h01, 1'b0};
    vecs[4]  = '{0, 3'd3, 8'h0F, 8'h01, 8'h0F, 1'b0};
    vecs[5]  = '{0, 3'd4, 8'h0F, 8'h01, 8'hEF, 1'b0};
    vecs[6]  = '{0, 3'd5, 8'h0F, 8'h01, 8'hF1, 1'b0};
    vecs[7]  = '{0, 3'd6, 8'h0F, 8'h01, 8'hFE, 1'b0};
    vecs[8]  = '{0, 3'd7, 8'h0F, 8'h01, 8'hF0, 1'b0};
    vecs[9]  = '{0, 3'd1, 8'h05, 8'h05, 8'h00, 1'b1};
    vecs[10] = '{3, 3'd7, 8'h00, 8'h00, 8'hFF, 1'b0};
    vecs[11] = '{2, 3'd4, 8'hFF, 8'h01, 8'hFF, 1'b0};
    vecs[12] = '{1, 3'd0, 8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[13] = '{1, 3'd1, 8'h00, 8'h01, 8'hFF, 1'b0};

    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_opc   = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    #12;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(res_valid), 32'h0);
    chk("rst_data",  32'(res_data),  32'h0);
    chk("rst_id",    32'(res_id),    32'h0);
    chk("rst_zero",  32'(res_zero),  32'h0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = '0;

    for (int k = 0; k < 14; k++) begin
      req_valid = '0;
      setreq(vecs[k].id, vecs[k].opc, vecs[k].a, vecs[k].b);
      req_valid = 4'(1 << vecs[k].id);
      #1;
      chk($sformatf("v%0d_ready", k), 32'(req_ready),
          32'(1 << vecs[k].id));
      tick();
      chk($sformatf("v%0d_valid", k), 32'(res_valid), 32'h1);
      chk($sformatf("v%0d_data", k), 32'(res_data),
          32'(vecs[k].exp_data));
      chk($sformatf("v%0d_id", k), 32'(res_id), 32'(vecs[k].id));
      chk($sformatf("v%0d_zero", k), 32'(res_zero),
          32'(vecs[k].exp_zero));
    end

    req_valid = '0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++)
      setreq(i, 3'(i), 8'(8'h30 + i), 8'h11);
    req_valid = 4'hF;
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rr%0d_ready", k), 32'(req_ready),
          32'(1 << (k % 4)));
      tick();
      chk($sformatf("rr%0d_valid", k), 32'(res_valid), 32'h1);
      chk($sformatf("rr%0d_id", k), 32'(res_id), 32'(k % 4));
      chk($sformatf("rr%0d_data", k), 32'(res_data),
          32'(alu_m(3'(k % 4), 8'(8'h30 + k % 4), 8'h11)));
    end

    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp%0d_ready", k), 32'(req_ready), 32'h0);
      chk($sformatf("bp%0d_valid", k), 32'(res_valid), 32'h1);
      chk($sformatf("bp%0d_id", k), 32'(res_id), 32'h0);
      chk($sformatf("bp%0d_data", k), 32'(res_data), 32'h41);
      tick();
    end
    res_ready = 1'b1;
    #1;
    chk("bp_resume_ready", 32'(req_ready), 32'h2);
    tick();
    chk("bp_resume_id", 32'(res_id), 32'h1);

    req_valid = 4'b0100;
    #1;
    chk("wrap0_ready", 32'(req_ready), 32'h4);
    tick();
    chk("wrap0_id", 32'(res_id), 32'h2);
    #1;
    chk("wrap1_ready", 32'(req_ready), 32'h4);
    tick();
    chk("wrap1_id", 32'(res_id), 32'h2);
    req_valid = 4'hF;
    #1;
    chk("ptr3_ready", 32'(req_ready), 32'h8);
    tick();
    chk("ptr3_id", 32'(res_id), 32'h3);

    res_ready = 1'b0;
    tick();
    chk("hold_valid", 32'(res_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(res_valid), 32'h0);
    chk("mrst_ready", 32'(req_ready), 32'h0);
    chk("mrst_id", 32'(res_id), 32'h0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = 4'b1100;
    res_ready = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'h4);
    tick();
    chk("post_rst_id", 32'(res_id), 32'h2);
    chk("post_rst_valid", 32'(res_valid), 32'h1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
